memu: RTL and testbench

Memory-access stage directly downstream of exu. It consumes exu's memory controls, address and store data plus its writeback fields. It drives a valid/data_ok data-bus request for loads and stores, and aligns store data and byte strobes. It extracts and sign- or zero-extends load data, and stalls the pipeline until the access completes. Non-memory instructions pass straight through to wbu.

---
 rtl/memu_if.sv | 24 ++
 rtl/memu.sv | 128 ++++++++++++
 tb/tb_memu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memu_if.sv
// Data-bus handshake between the memory-access stage and the data memory:
// a held valid request answered by a single data_ok response.
interface memu_if #(
   parameter int XLEN      = 64,
   parameter int BUS_BYTES = 8
);
   logic                 dreq_valid_o;
   logic [XLEN-1:0]      dreq_addr_o;
   logic [2:0]           dreq_size_o;
   logic [BUS_BYTES-1:0] dreq_strobe_o;
   logic [XLEN-1:0]      dreq_data_o;
   logic                 dresp_data_ok_i;
   logic [XLEN-1:0]      dresp_data_i;

   modport master (
      output dreq_valid_o, dreq_addr_o, dreq_size_o, dreq_strobe_o, dreq_data_o,
      input  dresp_data_ok_i, dresp_data_i
   );

   modport slave (
      input  dreq_valid_o, dreq_addr_o, dreq_size_o, dreq_strobe_o, dreq_data_o,
      output dresp_data_ok_i, dresp_data_i
   );
endinterface

// File: rtl/memu.sv
// Memory-access stage: issues aligned load/store requests on the data bus,
// stalls until data_ok, then extends load data for writeback.
module memu #(
   parameter int XLEN        = 64,
   parameter int BUS_BYTES   = 8,
   parameter int WBSEL_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [XLEN-1:0]        instaddr_i,
   input  logic [31:0]            inst_i,
   input  logic [WBSEL_WIDTH-1:0] WBsel_i,
   input  logic                   RFwe_i,
   input  logic [4:0]             rdaddr_i,
   input  logic [XLEN-1:0]        rd_wdata_i,
   input  logic                   DMre_i,
   input  logic                   DMwe_i,
   input  logic [2:0]             dreq_info_i,
   input  logic [XLEN-1:0]        mem_addr_i,
   input  logic [XLEN-1:0]        mem_wdata_i,
   memu_if.master                 bus,
   output logic                   stall_req_o,
   output logic                   misalign_o,
   output logic [XLEN-1:0]        instaddr_o,
   output logic [31:0]            inst_o,
   output logic [WBSEL_WIDTH-1:0] WBsel_o,
   output logic [4:0]             rdaddr_o,
   output logic                   RFwe_o,
   output logic [XLEN-1:0]        rd_wdata_o
);
   localparam int OFFW = $clog2(BUS_BYTES);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t               state;
   logic [XLEN-1:0]      load_data;
   logic                 mem_op;
   logic                 is_load;
   logic                 aligned;
   logic                 start;
   logic                 misaligned;
   logic                 sgn;
   logic [1:0]           size;
   logic [OFFW-1:0]      offset;
   logic [BUS_BYTES-1:0] size_mask;
   logic [BUS_BYTES-1:0] strobe;
   logic [XLEN-1:0]      wdata_lane;
   logic [XLEN-1:0]      load_shift;
   logic [XLEN-1:0]      load_ext;

   always_comb begin
      mem_op  = DMre_i | DMwe_i;
      is_load = DMre_i & ~DMwe_i;
      size    = dreq_info_i[1:0];
      offset  = mem_addr_i[OFFW-1:0];
      case (size)
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = ~mem_addr_i[0];
         2'd2:    aligned = (mem_addr_i[1:0] == 2'b00);
         default: aligned = (mem_addr_i[2:0] == 3'b000);
      endcase
      start      = (state == IDLE) & mem_op & aligned;
      misaligned = (state == IDLE) & mem_op & ~aligned;
      for (int i = 0; i < BUS_BYTES; i++) begin
         size_mask[i] = (i < (1 << size));
      end
      strobe     = DMwe_i ? (size_mask << offset) : '0;
      wdata_lane = mem_wdata_i << {offset, 3'b000};
   end

   // Extraction uses the frozen request address/size, so it stays valid in DONE.
   always_comb begin
      sgn        = ~dreq_info_i[2];
      load_shift = load_data >> {bus.dreq_addr_o[OFFW-1:0], 3'b000};
      case (bus.dreq_size_o[1:0])
         2'd0:    load_ext = {{(XLEN-8){sgn & load_shift[7]}}, load_shift[7:0]};
         2'd1:    load_ext = {{(XLEN-16){sgn & load_shift[15]}}, load_shift[15:0]};
         2'd2:    load_ext = {{(XLEN-32){sgn & load_shift[31]}}, load_shift[31:0]};
         default: load_ext = load_shift;
      endcase
   end

   always_comb begin
      stall_req_o = (state == REQ) | start;
      instaddr_o  = instaddr_i;
      inst_o      = inst_i;
      WBsel_o     = WBsel_i;
      rdaddr_o    = rdaddr_i;
      RFwe_o      = RFwe_i & ~misaligned;
      rd_wdata_o  = ((state == DONE) && is_load) ? load_ext : rd_wdata_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         bus.dreq_valid_o  <= 1'b0;
         bus.dreq_addr_o   <= '0;
         bus.dreq_size_o   <= '0;
         bus.dreq_strobe_o <= '0;
         bus.dreq_data_o   <= '0;
         load_data         <= '0;
         misalign_o        <= 1'b0;
      end else begin
         misalign_o <= misaligned;
         case (state)
            IDLE: begin
               if (start) begin
                  state             <= REQ;
                  bus.dreq_valid_o  <= 1'b1;
                  bus.dreq_addr_o   <= mem_addr_i;
                  bus.dreq_size_o   <= {1'b0, size};
                  bus.dreq_strobe_o <= strobe;
                  bus.dreq_data_o   <= wdata_lane;
               end
            end
            REQ: begin
               if (bus.dresp_data_ok_i) begin
                  bus.dreq_valid_o <= 1'b0;
                  load_data        <= bus.dresp_data_i;
                  state            <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_memu.sv
// Directed scoreboard bench for memu: expected request fields and writeback
// data are queued when an access is driven and consumed as the DUT answers.
module tb_memu;
   logic        clk;
   logic        rst;
   logic [63:0] instaddr_i;
   logic [31:0] inst_i;
   logic [1:0]  WBsel_i;
   logic        RFwe_i;
   logic [4:0]  rdaddr_i;
   logic [63:0] rd_wdata_i;
   logic        DMre_i;
   logic        DMwe_i;
   logic [2:0]  dreq_info_i;
   logic [63:0] mem_addr_i;
   logic [63:0] mem_wdata_i;
   logic        stall_req_o;
   logic        misalign_o;
   logic [63:0] instaddr_o;
   logic [31:0] inst_o;
   logic [1:0]  WBsel_o;
   logic [4:0]  rdaddr_o;
   logic        RFwe_o;
   logic [63:0] rd_wdata_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [63:0] rd;
      logic        rfwe;
   } exp_t;

   exp_t exp_q[$];

   memu_if #(.XLEN(64), .BUS_BYTES(8)) bus ();

   memu dut (
      .clk(clk), .rst(rst),
      .instaddr_i(instaddr_i), .inst_i(inst_i), .WBsel_i(WBsel_i),
      .RFwe_i(RFwe_i), .rdaddr_i(rdaddr_i), .rd_wdata_i(rd_wdata_i),
      .DMre_i(DMre_i), .DMwe_i(DMwe_i), .dreq_info_i(dreq_info_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .bus(bus),
      .stall_req_o(stall_req_o), .misalign_o(misalign_o),
      .instaddr_o(instaddr_o), .inst_o(inst_o), .WBsel_o(WBsel_o),
      .rdaddr_o(rdaddr_o), .RFwe_o(RFwe_o), .rd_wdata_o(rd_wdata_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic re, input logic we, input logic [2:0] info,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdw, input logic rfwe);
      DMre_i      = re;
      DMwe_i      = we;
      dreq_info_i = info;
      mem_addr_i  = addr;
      mem_wdata_i = wdata;
      rd_wdata_i  = rdw;
      RFwe_i      = rfwe;
      instaddr_i  = instaddr_i + 64'd4;
      inst_i      = $urandom;
      rdaddr_i    = 5'($urandom);
      WBsel_i     = 2'($urandom);
   endtask

   task automatic pushExpected(input logic [63:0] addr, input logic [2:0] size,
                               input logic [7:0] strobe, input logic [63:0] data,
                               input logic [63:0] rd, input logic rfwe);
      exp_t e;
      e.addr = addr; e.size = size; e.strobe = strobe;
      e.data = data; e.rd = rd; e.rfwe = rfwe;
      exp_q.push_back(e);
   endtask

   task automatic checkRequest(input string tag);
      checkOutput({tag, " valid"}, 64'(bus.dreq_valid_o), 64'd1);
      checkOutput({tag, " stall"}, 64'(stall_req_o), 64'd1);
      checkOutput({tag, " addr"}, bus.dreq_addr_o, exp_q[0].addr);
      checkOutput({tag, " size"}, 64'(bus.dreq_size_o), 64'(exp_q[0].size));
      checkOutput({tag, " strobe"}, 64'(bus.dreq_strobe_o), 64'(exp_q[0].strobe));
      checkOutput({tag, " data"}, bus.dreq_data_o, exp_q[0].data);
   endtask

   // Entered at posedge+1 of the IDLE cycle; returns at posedge+1 of the next IDLE.
   task automatic runAccess(input string tag, input int okDelay, input logic [63:0] raw);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s scoreboard: observed=empty expected=entry", tag);
         return;
      end
      @(negedge clk);
      checkOutput({tag, " idle stall"}, 64'(stall_req_o), 64'd1);
      checkOutput({tag, " idle valid"}, 64'(bus.dreq_valid_o), 64'd0);
      @(posedge clk); #1;
      for (int i = 0; i < okDelay; i++) begin
         bus.dresp_data_i = {$urandom, $urandom};
         @(negedge clk);
         checkRequest({tag, " wait"});
         @(posedge clk); #1;
      end
      bus.dresp_data_ok_i = 1'b1;
      bus.dresp_data_i    = raw;
      @(negedge clk);
      checkRequest({tag, " req"});
      @(posedge clk); #1;
      bus.dresp_data_ok_i = 1'b0;
      bus.dresp_data_i    = {$urandom, $urandom};
      @(negedge clk);
      e = exp_q.pop_front();
      checkOutput({tag, " done valid"}, 64'(bus.dreq_valid_o), 64'd0);
      checkOutput({tag, " done stall"}, 64'(stall_req_o), 64'd0);
      checkOutput({tag, " done rd_wdata"}, rd_wdata_o, e.rd);
      checkOutput({tag, " done RFwe"}, 64'(RFwe_o), 64'(e.rfwe));
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0;
      instaddr_i = 64'h8000_0000;
      applyStimulus(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
      bus.dresp_data_ok_i = 1'b0;
      bus.dresp_data_i    = 64'd0;
      repeat (2) @(negedge clk);
      checkOutput("reset valid", 64'(bus.dreq_valid_o), 64'd0);
      checkOutput("reset addr", bus.dreq_addr_o, 64'd0);
      checkOutput("reset size", 64'(bus.dreq_size_o), 64'd0);
      checkOutput("reset strobe", 64'(bus.dreq_strobe_o), 64'd0);
      checkOutput("reset data", bus.dreq_data_o, 64'd0);
      checkOutput("reset misalign", 64'(misalign_o), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'd0, 64'h55, 1'b1);
      pushExpected(64'h8000_0010, 3'd3, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b1);
      runAccess("LD", 0, 64'h1122_3344_5566_7788);

      applyStimulus(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h66, 1'b1);
      pushExpected(64'h8000_0003, 3'd0, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF85, 1'b1);
      runAccess("LB", 0, 64'h1111_1111_8522_2222);

      applyStimulus(1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'd0, 64'h66, 1'b1);
      pushExpected(64'h8000_0003, 3'd0, 8'h00, 64'd0, 64'h85, 1'b1);
      runAccess("LBU", 1, 64'h1111_1111_8522_2222);

      applyStimulus(1'b1, 1'b0, 3'b001, 64'h8000_0004, 64'd0, 64'h77, 1'b1);
      pushExpected(64'h8000_0004, 3'd1, 8'h00, 64'd0, 64'h6655, 1'b1);
      runAccess("LH", 0, 64'h8877_6655_4433_2211);

      applyStimulus(1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'd0, 64'h77, 1'b1);
      pushExpected(64'h8000_0004, 3'd2, 8'h00, 64'd0, 64'hFFFF_FFFF_8877_6655, 1'b1);
      runAccess("LW", 0, 64'h8877_6655_4433_2211);

      applyStimulus(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'h77, 1'b1);
      pushExpected(64'h8000_0004, 3'd2, 8'h00, 64'd0, 64'h8877_6655, 1'b1);
      runAccess("LWU", 0, 64'h8877_6655_4433_2211);

      applyStimulus(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'hBEEF, 64'h1234, 1'b0);
      pushExpected(64'h8000_0006, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h1234, 1'b0);
      runAccess("SH", 4, 64'd0);

      applyStimulus(1'b0, 1'b1, 3'b010, 64'h8000_0004, 64'h1234_5678_CAFE_F00D, 64'h99, 1'b0);
      pushExpected(64'h8000_0004, 3'd2, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'h99, 1'b0);
      runAccess("SW", 1, 64'd0);

      applyStimulus(1'b1, 1'b1, 3'b000, 64'h8000_0001, 64'hA5, 64'h42, 1'b0);
      pushExpected(64'h8000_0001, 3'd0, 8'h02, 64'hA500, 64'h42, 1'b0);
      runAccess("SB both", 0, 64'hFFFF_FFFF_FFFF_FFFF);

      // Misaligned LW: immediate RFwe kill, misalign pulse on the following cycle.
      applyStimulus(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'h10, 1'b1);
      @(negedge clk);
      checkOutput("misalign stall", 64'(stall_req_o), 64'd0);
      checkOutput("misalign RFwe", 64'(RFwe_o), 64'd0);
      checkOutput("misalign valid", 64'(bus.dreq_valid_o), 64'd0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'h2A, 1'b1);
      @(negedge clk);
      checkOutput("misalign pulse", 64'(misalign_o), 64'd1);
      checkOutput("misalign no req", 64'(bus.dreq_valid_o), 64'd0);
      checkOutput("ADD rd_wdata", rd_wdata_o, 64'h2A);
      checkOutput("ADD stall", 64'(stall_req_o), 64'd0);
      checkOutput("ADD RFwe", 64'(RFwe_o), 64'd1);
      checkOutput("ADD inst", 64'(inst_o), 64'(inst_i));
      checkOutput("ADD instaddr", instaddr_o, instaddr_i);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("misalign end", 64'(misalign_o), 64'd0);
      @(posedge clk); #1;

      // Reset in REQ, then a stray data_ok while IDLE.
      applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'd0, 64'h0, 1'b1);
      @(negedge clk);
      checkOutput("abort idle stall", 64'(stall_req_o), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("abort req valid", 64'(bus.dreq_valid_o), 64'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("abort valid drop", 64'(bus.dreq_valid_o), 64'd0);
      applyStimulus(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'h31, 1'b1);
      #1;
      checkOutput("abort stall drop", 64'(stall_req_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      bus.dresp_data_ok_i = 1'b1;
      bus.dresp_data_i    = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      checkOutput("late ok valid", 64'(bus.dreq_valid_o), 64'd0);
      checkOutput("late ok stall", 64'(stall_req_o), 64'd0);
      checkOutput("late ok rd_wdata", rd_wdata_o, 64'h31);
      @(posedge clk); #1;
      bus.dresp_data_ok_i = 1'b0;
      @(negedge clk);
      checkOutput("late ok no req", 64'(bus.dreq_valid_o), 64'd0);
      @(posedge clk); #1;

      applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_0028, 64'd0, 64'h0, 1'b1);
      pushExpected(64'h8000_0028, 3'd3, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b1);
      runAccess("LD after reset", 1, 64'h0123_4567_89AB_CDEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
